// File: rtl/vc_rr_pop_arbiter_if.sv
// Handshake bundle between the per-VC FIFOs, the pop arbiter and the egress stage.
// The master modport is the arbiter side; the slave modport is the FIFO/egress side.
interface vc_rr_pop_arbiter_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_VC    = 4
);
    localparam int VC_W = $clog2(NUM_VC);

    logic [NUM_VC-1:0]           fifo_empty;
    logic [NUM_VC*DATA_SIZE-1:0] fifo_data;
    logic [NUM_VC-1:0]           fifo_read;
    logic                        dest_pause;
    logic [DATA_SIZE-1:0]        data_out;
    logic                        valid_out;
    logic [VC_W-1:0]             vc_out;
    logic                        busy;

    modport master (
        input  fifo_empty, fifo_data, dest_pause,
        output fifo_read, data_out, valid_out, vc_out, busy
    );

    modport slave (
        output fifo_empty, fifo_data, dest_pause,
        input  fifo_read, data_out, valid_out, vc_out, busy
    );
endinterface

// File: rtl/vc_rr_pop_arbiter.sv
// Round-robin pop arbiter over NUM_VC upstream FIFOs: POP pulses one read, CAPTURE latches the word.
// Optional macro STRICT_VC0_EN gives VC0 strict priority over the round-robin set.
module vc_rr_pop_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_VC    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vc_rr_pop_arbiter_if.master  bus
);
    localparam int VC_W = $clog2(NUM_VC);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] POP     = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]           state;
    logic [VC_W-1:0]      last_grant;
    logic [VC_W-1:0]      grant;
    logic [VC_W-1:0]      next_grant;
    logic                 go;
    logic [NUM_VC-1:0]    fifo_read;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic [VC_W-1:0]      vc_out;

    // First non-empty VC after last_grant, wrapping modulo NUM_VC.
    always_comb begin
        logic found;
        int   idx;
        found      = 1'b0;
        idx        = 0;
        next_grant = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = (int'(last_grant) + i) % NUM_VC;
            if (!found && !bus.fifo_empty[idx]) begin
                found      = 1'b1;
                next_grant = VC_W'(idx);
            end
        end
`ifdef STRICT_VC0_EN
        if (!bus.fifo_empty[0])
            next_grant = '0;
`endif
    end

    // dest_pause only gates the decision to start a pop, never one in flight.
    assign go = ~&bus.fifo_empty && !bus.dest_pause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= VC_W'(NUM_VC - 1);
            grant      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            vc_out     <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        grant <= next_grant;
                        state <= POP;
                    end
                end
                POP: begin
                    last_grant <= grant;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    data_out  <= bus.fifo_data[int'(grant)*DATA_SIZE +: DATA_SIZE];
                    vc_out    <= grant;
                    valid_out <= 1'b1;
                    if (go) begin
                        grant <= next_grant;
                        state <= POP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_read = '0;
        if (state == POP)
            fifo_read[grant] = 1'b1;
    end

    assign bus.fifo_read = fifo_read;
    assign bus.data_out  = data_out;
    assign bus.valid_out = valid_out;
    assign bus.vc_out    = vc_out;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_vc_rr_pop_arbiter.sv
// Directed bench for vc_rr_pop_arbiter with a behavioural FIFO model per VC and delivery logs.
module tb_vc_rr_pop_arbiter;
    localparam int DS    = 8;
    localparam int NV    = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_rr_pop_arbiter_if #(.DATA_SIZE(DS), .NUM_VC(NV)) bus ();
    vc_rr_pop_arbiter #(.DATA_SIZE(DS), .NUM_VC(NV)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // FIFO model: word appears on data the cycle after the read; empty updates then too.
    logic [DS-1:0]    mem [NV][DEPTH];
    int               wr_cnt [NV] = '{default: 0};
    int               rd_ptr [NV] = '{default: 0};
    logic [DS-1:0]    data_reg [NV] = '{default: '0};
    logic [NV-1:0]    emp;
    logic [NV*DS-1:0] fdat;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NV; i++)
            if (bus.fifo_read[i] && rd_ptr[i] != wr_cnt[i]) begin
                data_reg[i] <= mem[i][rd_ptr[i]];
                rd_ptr[i]   <= rd_ptr[i] + 1;
            end
    end

    always_comb begin
        emp  = '0;
        fdat = '0;
        for (int i = 0; i < NV; i++) begin
            emp[i]          = (rd_ptr[i] == wr_cnt[i]);
            fdat[i*DS +: DS] = data_reg[i];
        end
    end
    assign bus.fifo_empty = emp;
    assign bus.fifo_data  = fdat;

    int          pop_vc[$];
    int          pop_cyc[$];
    int          got_vc[$];
    int          got_cyc[$];
    logic [7:0]  got_dat[$];

    always @(negedge clk) begin
        if (bus.fifo_read != 0) begin
            total++;
            if ($countones(bus.fifo_read) != 1 || (bus.fifo_read & bus.fifo_empty) != 0) begin
                bad++;
                $display("FAIL read_legal: fifo_read=%b fifo_empty=%b, need one-hot on a non-empty VC",
                         bus.fifo_read, bus.fifo_empty);
            end
            for (int i = 0; i < NV; i++)
                if (bus.fifo_read[i]) begin
                    pop_vc.push_back(i);
                    pop_cyc.push_back(cyc);
                end
        end
        if (bus.valid_out) begin
            got_vc.push_back(int'(bus.vc_out));
            got_dat.push_back(bus.data_out);
            got_cyc.push_back(cyc);
        end
    end

    task automatic load(input int vc, input logic [7:0] d);
        mem[vc][wr_cnt[vc]] = d;
        wr_cnt[vc]++;
    endtask

    task automatic clear_logs();
        pop_vc.delete(); pop_cyc.delete();
        got_vc.delete(); got_dat.delete(); got_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        clear_logs();
        reset = 1'b1;
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.busy && &bus.fifo_empty) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.fifo_read != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit         ok;
        int         ev[3] = '{0, 1, 3};
        logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
        reset = 1'b0;
        bus.dest_pause = 1'($urandom_range(0, 1));
        load(0, 8'h11); load(1, 8'h22); load(3, 8'h33);
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.fifo_read !== 4'b0) begin bad++; $display("FAIL rst_read: got %b need 0000", bus.fifo_read); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_data: got %h need 00", bus.data_out); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b need 0", bus.valid_out); end
        total++; if (bus.vc_out !== 2'd0) begin bad++; $display("FAIL rst_vc: got %0d need 0", bus.vc_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b need 0", bus.busy); end
        bus.dest_pause = 1'b0;
        clear_logs();
        reset = 1'b1;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_timeout: busy=%b empty=%b, need idle", bus.busy, bus.fifo_empty); end
        total++; if (pop_vc.size() == 0 || pop_vc[0] != 0) begin bad++; $display("FAIL rst_first_grant: pops=%0d, need first grant VC0", pop_vc.size()); end
        total++; if (got_vc.size() != 3) begin bad++; $display("FAIL rst_count: got %0d words need 3", got_vc.size()); end
        for (int k = 0; k < 3 && k < got_vc.size(); k++) begin
            total++;
            if (got_vc[k] != ev[k] || got_dat[k] !== ed[k]) begin
                bad++; $display("FAIL rst_word%0d: vc=%0d data=%h need vc=%0d data=%h", k, got_vc[k], got_dat[k], ev[k], ed[k]);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        load(2, 8'hA5);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: busy=%b", bus.busy); end
        total++; if (pop_vc.size() != 1 || pop_vc[0] != 2) begin bad++; $display("FAIL single_pop: pops=%0d, need one read on VC2", pop_vc.size()); end
        total++;
        if (got_vc.size() != 1 || got_vc[0] != 2 || got_dat[0] !== 8'hA5) begin
            bad++; $display("FAIL single_word: count=%0d, need one word vc=2 data=a5", got_vc.size());
        end
        total++;
        if (got_cyc.size() != 1 || pop_cyc.size() != 1 || got_cyc[0] - pop_cyc[0] != 2) begin
            bad++; $display("FAIL single_latency: pops=%0d words=%0d, need valid two cycles after read", pop_cyc.size(), got_cyc.size());
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b need 0", bus.busy); end
    endtask

    task automatic test_rr();
        bit ok;
        do_reset();
        for (int w = 0; w < 3; w++)
            for (int v = 0; v < NV; v++)
                load(v, 8'(8'h10 * (v + 1) + w));
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout: busy=%b", bus.busy); end
        total++; if (pop_vc.size() != 12) begin bad++; $display("FAIL rr_pop_count: got %0d need 12", pop_vc.size()); end
        total++; if (got_vc.size() != 12) begin bad++; $display("FAIL rr_valid_count: got %0d need 12", got_vc.size()); end
        for (int k = 0; k < 12 && k < pop_vc.size(); k++) begin
            total++;
            if (pop_vc[k] != k % 4 || (k > 0 && pop_cyc[k] - pop_cyc[k-1] != 2)) begin
                bad++; $display("FAIL rr_pop%0d: vc=%0d need vc=%0d every 2 cycles", k, pop_vc[k], k % 4);
            end
        end
        for (int k = 0; k < 12 && k < got_vc.size(); k++) begin
            total++;
            if (got_vc[k] != k % 4 || got_dat[k] !== 8'(8'h10 * (k % 4 + 1) + k / 4)) begin
                bad++; $display("FAIL rr_word%0d: vc=%0d data=%h need vc=%0d data=%h", k, got_vc[k], got_dat[k],
                                k % 4, 8'(8'h10 * (k % 4 + 1) + k / 4));
            end
        end
    endtask

    task automatic test_pause();
        bit ok;
        do_reset();
        bus.dest_pause = 1'b1;
        load(1, 8'hB1); load(1, 8'hB2); load(2, 8'hC1);
        repeat (5) @(negedge clk);
        #1;
        total++; if (pop_vc.size() != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL pause_hold: pops=%0d busy=%b need 0 0", pop_vc.size(), bus.busy); end
        bus.dest_pause = 1'b0;
        wait_read(ok);
        total++; if (!ok) begin bad++; $display("FAIL pause_timeout: no read after release"); end
        bus.dest_pause = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        total++; if (pop_vc.size() != 1 || pop_vc[0] != 1) begin bad++; $display("FAIL pause_inflight_pop: pops=%0d, need only VC1", pop_vc.size()); end
        total++;
        if (got_vc.size() != 1 || got_vc[0] != 1 || got_dat[0] !== 8'hB1 || got_cyc[0] - pop_cyc[0] != 2) begin
            bad++; $display("FAIL pause_inflight_word: count=%0d, need vc=1 data=b1 two cycles after read", got_vc.size());
        end
        clear_logs();
        bus.dest_pause = 1'b0;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL pause_resume_timeout: busy=%b", bus.busy); end
        total++;
        if (got_vc.size() != 2 || got_vc[0] != 2 || got_dat[0] !== 8'hC1 || got_vc[1] != 1 || got_dat[1] !== 8'hB2) begin
            bad++; $display("FAIL pause_resume: count=%0d, need (2,c1) then (1,b2)", got_vc.size());
        end
    endtask

    task automatic test_reset_midop();
        bit         ok;
        int         ev[3] = '{0, 2, 3};
        logic [7:0] ed[3] = '{8'hE1, 8'hD2, 8'hF1};
        do_reset();
        load(2, 8'hD1); load(2, 8'hD2);
        wait_read(ok);
        total++; if (!ok) begin bad++; $display("FAIL midop_timeout: no read issued"); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.fifo_read !== 4'b0) begin
            bad++; $display("FAIL midop_async: valid=%b busy=%b read=%b need 0 0 0000", bus.valid_out, bus.busy, bus.fifo_read);
        end
        @(negedge clk);
        #1;
        total++; if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
            bad++; $display("FAIL midop_drop: valid=%b data=%h need 0 00", bus.valid_out, bus.data_out);
        end
        load(0, 8'hE1); load(3, 8'hF1);
        clear_logs();
        reset = 1'b1;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL midop_resume_timeout: busy=%b", bus.busy); end
        total++; if (got_vc.size() != 3) begin bad++; $display("FAIL midop_count: got %0d words need 3", got_vc.size()); end
        for (int k = 0; k < 3 && k < got_vc.size(); k++) begin
            total++;
            if (got_vc[k] != ev[k] || got_dat[k] !== ed[k]) begin
                bad++; $display("FAIL midop_word%0d: vc=%0d data=%h need vc=%0d data=%h", k, got_vc[k], got_dat[k], ev[k], ed[k]);
            end
        end
    endtask

    task automatic test_strict();
        bit         ok;
`ifdef STRICT_VC0_EN
        int         ev[4] = '{0, 0, 3, 3};
        logic [7:0] ed[4] = '{8'h61, 8'h62, 8'h71, 8'h72};
`else
        int         ev[4] = '{0, 3, 0, 3};
        logic [7:0] ed[4] = '{8'h61, 8'h71, 8'h62, 8'h72};
`endif
        do_reset();
        load(0, 8'h61); load(0, 8'h62); load(3, 8'h71); load(3, 8'h72);
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL prio_timeout: busy=%b", bus.busy); end
        total++; if (got_vc.size() != 4) begin bad++; $display("FAIL prio_count: got %0d words need 4", got_vc.size()); end
        for (int k = 0; k < 4 && k < got_vc.size(); k++) begin
            total++;
            if (got_vc[k] != ev[k] || got_dat[k] !== ed[k]) begin
                bad++; $display("FAIL prio_word%0d: vc=%0d data=%h need vc=%0d data=%h", k, got_vc[k], got_dat[k], ev[k], ed[k]);
            end
        end
    endtask

    initial begin
        bus.dest_pause = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_pause();
        test_reset_midop();
        test_strict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
